// File: rtl/cfi_log_buffer.sv
// Multi-port compacting log buffer between the CFI filter and the CFI backend.
// Up to NR_COMMIT_PORTS logs enter per cycle and leave one at a time on a valid/ready port.
module cfi_log_buffer #(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned DEPTH           = 8,
   parameter int unsigned LOG_W           = 128,
   parameter int unsigned OVERFLOW_MODE   = 0,
   parameter int unsigned HALT_MARGIN     = NR_COMMIT_PORTS,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NR_COMMIT_PORTS*LOG_W-1:0] log_i,
   input  logic [NR_COMMIT_PORTS-1:0]       log_valid_i,
   input  logic                             flush_i,
   input  logic                             drop_clr_i,
   output logic                             halt_o,
   output logic [LOG_W-1:0]                 log_o,
   output logic                             log_valid_o,
   input  logic                             log_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]       usage_o,
   output logic [CNT_W-1:0]                 drop_cnt_o,
   output logic                             overflow_o
);

   localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned USE_W      = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W      = USE_W + 1;
   localparam int unsigned PORT_W     = $clog2(NR_COMMIT_PORTS + 1);
   localparam int unsigned SAT_W      = ((CNT_W > PORT_W) ? CNT_W : PORT_W) + 1;
   localparam int unsigned HALT_LEVEL = DEPTH - HALT_MARGIN;
   localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [LOG_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [USE_W-1:0]  usage_reg, usage_next;
   logic              halt_reg, halt_next;
   logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
   logic              overflow_reg, overflow_next;

   logic              pop;
   logic [SUM_W-1:0]  room;
   logic [PORT_W-1:0] offset [NR_COMMIT_PORTS];
   logic [NR_COMMIT_PORTS-1:0] accept;
   logic [PORT_W-1:0] valid_cnt;
   logic [SUM_W-1:0]  accepted;
   logic [SUM_W-1:0]  dropped;
   logic [SAT_W-1:0]  drop_sum;
   logic [PTR_W-1:0]  wr_addr [NR_COMMIT_PORTS];
   logic [LOG_W-1:0]  port_log [NR_COMMIT_PORTS];

   assign log_valid_o = (usage_reg != '0);
   assign pop         = log_valid_o & log_ready_i;
   // A slot vacated by this cycle's pop may be refilled in the same cycle.
   assign room        = SUM_W'(DEPTH) - SUM_W'(usage_reg) + SUM_W'(pop);

   // Each valid port lands at an offset equal to the number of valid ports below it.
   always_comb begin
      logic [PORT_W-1:0] cnt_v;
      cnt_v = '0;
      for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
         offset[p] = cnt_v;
         accept[p] = log_valid_i[p] && (SUM_W'(cnt_v) < room);
         cnt_v     = cnt_v + PORT_W'(log_valid_i[p]);
      end
      valid_cnt = cnt_v;
   end

   assign accepted = (SUM_W'(valid_cnt) < room) ? SUM_W'(valid_cnt) : room;
   assign dropped  = SUM_W'(valid_cnt) - accepted;

   generate
      for (genvar gi = 0; gi < int'(NR_COMMIT_PORTS); gi++) begin : g_port
         assign port_log[gi] = log_i[gi*LOG_W +: LOG_W];
         assign wr_addr[gi]  = (wr_ptr_reg + PTR_W'(offset[gi])) & PTR_MASK;
      end
   endgenerate

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      usage_next    = usage_reg;
      halt_next     = 1'b0;
      drop_sum      = '0;
      drop_cnt_next = drop_cnt_reg;
      overflow_next = overflow_reg;
      if (flush_i) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         usage_next  = '0;
         if (drop_clr_i) begin
            drop_cnt_next = '0;
            overflow_next = 1'b0;
         end
      end else begin
         wr_ptr_next = (wr_ptr_reg + PTR_W'(accepted)) & PTR_MASK;
         rd_ptr_next = (rd_ptr_reg + PTR_W'(pop)) & PTR_MASK;
         usage_next  = USE_W'(SUM_W'(usage_reg) + accepted - SUM_W'(pop));
         halt_next   = (OVERFLOW_MODE == 0) && (usage_next > USE_W'(HALT_LEVEL));
         // Clearing restarts from this cycle's drops so none are lost.
         drop_sum    = (drop_clr_i ? SAT_W'(0) : SAT_W'(drop_cnt_reg)) + SAT_W'(dropped);
         drop_cnt_next = (drop_sum > SAT_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
         overflow_next = (drop_clr_i ? 1'b0 : overflow_reg) | (dropped != '0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         usage_reg    <= '0;
         halt_reg     <= 1'b0;
         drop_cnt_reg <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         usage_reg    <= usage_next;
         halt_reg     <= halt_next;
         drop_cnt_reg <= drop_cnt_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage is not reset; accepted ports always target distinct slots.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
         if (!flush_i && accept[p]) begin
            mem[wr_addr[p]] <= port_log[p];
         end
      end
   end

   assign log_o      = mem[rd_ptr_reg];
   assign halt_o     = halt_reg;
   assign usage_o    = usage_reg;
   assign drop_cnt_o = drop_cnt_reg;
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_cfi_log_buffer.sv
// Scoreboard bench: a HALT instance (DEPTH 4) and a DROP instance (DEPTH 8) share random stimulus;
// a queue-based reference model predicts status and output order, a negedge monitor compares.
module tb_cfi_log_buffer;
   localparam int LW   = 16;
   localparam int CMAX = 15;

   typedef struct {
      int usage;
      bit halt;
      bit valid;
      int cnt;
      bit ovf;
   } stat_t;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic [2*LW-1:0] log_i = '0;
   logic [1:0]    log_valid_i = '0;
   logic          flush_i = 1'b0;
   logic          drop_clr_i = 1'b0;
   logic          log_ready_i = 1'b0;

   logic          halt_h, halt_d, valid_h, valid_d, ovf_h, ovf_d;
   logic [LW-1:0] log_h, log_d;
   logic [2:0]    usage_h;
   logic [3:0]    usage_d;
   logic [3:0]    cnt_h, cnt_d;

   int m_depth [2] = '{4, 8};
   int m_hm    [2] = '{2, 2};
   int m_mode  [2] = '{0, 1};
   int m_size  [2];
   bit m_halt  [2];
   int m_cnt   [2];
   bit m_ovf   [2];
   logic [LW-1:0] exp_q  [2][$];
   stat_t         stat_q [2][$];

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   cfi_log_buffer #(.NR_COMMIT_PORTS(2), .DEPTH(4), .LOG_W(LW), .OVERFLOW_MODE(0),
                    .HALT_MARGIN(2), .CNT_W(4)) u_halt (
      .clk_i(clk), .rst_ni(rst_ni), .log_i(log_i), .log_valid_i(log_valid_i),
      .flush_i(flush_i), .drop_clr_i(drop_clr_i), .halt_o(halt_h), .log_o(log_h),
      .log_valid_o(valid_h), .log_ready_i(log_ready_i), .usage_o(usage_h),
      .drop_cnt_o(cnt_h), .overflow_o(ovf_h));

   cfi_log_buffer #(.NR_COMMIT_PORTS(2), .DEPTH(8), .LOG_W(LW), .OVERFLOW_MODE(1),
                    .HALT_MARGIN(2), .CNT_W(4)) u_drop (
      .clk_i(clk), .rst_ni(rst_ni), .log_i(log_i), .log_valid_i(log_valid_i),
      .flush_i(flush_i), .drop_clr_i(drop_clr_i), .halt_o(halt_d), .log_o(log_d),
      .log_valid_o(valid_d), .log_ready_i(log_ready_i), .usage_o(usage_d),
      .drop_cnt_o(cnt_d), .overflow_o(ovf_d));

   function automatic int d_usage(int i); return (i == 0) ? int'(usage_h) : int'(usage_d); endfunction
   function automatic int d_halt(int i);  return (i == 0) ? int'(halt_h)  : int'(halt_d);  endfunction
   function automatic int d_valid(int i); return (i == 0) ? int'(valid_h) : int'(valid_d); endfunction
   function automatic int d_cnt(int i);   return (i == 0) ? int'(cnt_h)   : int'(cnt_d);   endfunction
   function automatic int d_ovf(int i);   return (i == 0) ? int'(ovf_h)   : int'(ovf_d);   endfunction
   function automatic int d_log(int i);   return (i == 0) ? int'(log_h)   : int'(log_d);   endfunction

   task automatic chk(input string name, input int inst, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", name, inst, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_size[i] = 0; m_halt[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
         exp_q[i].delete();
         stat_q[i].delete();
      end
   endtask

   // Reference behaviour of one clock edge, from occupancy arithmetic on a plain queue.
   task automatic model_edge(input int i, input logic [1:0] v, input logic [2*LW-1:0] lg,
                             input logic rdy, input logic fl, input logic clr);
      int k, acc, room, d;
      bit pop;
      stat_t s;
      pop = (m_size[i] != 0) && rdy && !fl;
      if (fl) begin
         m_size[i] = 0;
         m_halt[i] = 0;
         exp_q[i].delete();
         if (clr) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      end else begin
         room = m_depth[i] - m_size[i] + int'(pop);
         k = 0; acc = 0;
         for (int p = 0; p < 2; p++) begin
            if (v[p]) begin
               k++;
               if (acc < room) begin
                  exp_q[i].push_back(lg[p*LW +: LW]);
                  acc++;
               end
            end
         end
         d = k - acc;
         m_size[i] = m_size[i] + acc - int'(pop);
         m_halt[i] = (m_mode[i] == 0) && ((m_depth[i] - m_size[i]) < m_hm[i]);
         if (clr) begin
            m_cnt[i] = (d > CMAX) ? CMAX : d;
            m_ovf[i] = (d != 0);
         end else begin
            m_cnt[i] = (m_cnt[i] + d > CMAX) ? CMAX : m_cnt[i] + d;
            m_ovf[i] = m_ovf[i] | (d != 0);
         end
      end
      s.usage = m_size[i]; s.halt = m_halt[i]; s.valid = (m_size[i] != 0);
      s.cnt = m_cnt[i]; s.ovf = m_ovf[i];
      stat_q[i].push_back(s);
   endtask

   task automatic step(input logic [1:0] v, input logic [2*LW-1:0] lg,
                       input logic rdy, input logic fl, input logic clr);
      log_valid_i = v; log_i = lg; log_ready_i = rdy; flush_i = fl; drop_clr_i = clr;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_edge(i, v, lg, rdy, fl, clr);
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_usage"}, i, d_usage(i), 0);
         chk({tag, "_valid"}, i, d_valid(i), 0);
         chk({tag, "_halt"},  i, d_halt(i),  0);
         chk({tag, "_cnt"},   i, d_cnt(i),   0);
         chk({tag, "_ovf"},   i, d_ovf(i),   0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_ni && mon_en) begin
         for (int i = 0; i < 2; i++) begin
            if (stat_q[i].size() > 0) begin
               stat_t s;
               s = stat_q[i].pop_front();
               chk("usage",    i, d_usage(i), s.usage);
               chk("halt",     i, d_halt(i),  int'(s.halt));
               chk("valid",    i, d_valid(i), int'(s.valid));
               chk("drop_cnt", i, d_cnt(i),   s.cnt);
               chk("overflow", i, d_ovf(i),   int'(s.ovf));
            end
            if (d_valid(i) != 0 && log_ready_i && !flush_i) begin
               if (exp_q[i].size() == 0) begin
                  chk("pop_on_empty_model", i, 1, 0);
               end else begin
                  logic [LW-1:0] e;
                  e = exp_q[i].pop_front();
                  chk("log_o", i, d_log(i), int'(e));
               end
            end
         end
      end
   end

   initial begin
      int rdy_pct;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(posedge clk);
      #2 rst_ni = 1'b1;

      // Single push/pop, then compaction order B, C, D.
      step(2'b01, {16'h0000, 16'h000A}, 1'b1, 1'b0, 1'b0);
      step(2'b00, '0, 1'b1, 1'b0, 1'b0);
      step(2'b00, '0, 1'b1, 1'b0, 1'b0);
      step(2'b10, {16'h000B, 16'h0000}, 1'b0, 1'b0, 1'b0);
      step(2'b11, {16'h000D, 16'h000C}, 1'b0, 1'b0, 1'b0);
      step(2'b00, '0, 1'b0, 1'b0, 1'b0);
      repeat (4) step(2'b00, '0, 1'b1, 1'b0, 1'b0);
      // Overfill with ready low, clear with a drop in the same cycle, then full+pop.
      repeat (6) step(2'b11, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      step(2'b11, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
      step(2'b11, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
      step(2'b11, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
      step(2'b00, '0, 1'b1, 1'b0, 1'b0);

      rdy_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) rdy_pct = $urandom_range(10, 95);
         if (c == 1500) begin
            #2 rst_ni = 1'b0;
            #1;
            chk_reset_outputs("async_reset");
            mon_en = 1'b0;
            model_reset();
            log_valid_i = '0; flush_i = 1'b0; drop_clr_i = 1'b0;
            @(posedge clk);
            #2 rst_ni = 1'b1;
         end
         step(2'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 99) < rdy_pct),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 19) == 0));
      end
      for (int i = 0; i < 2; i++) chk("final_depth", i, exp_q[i].size(), m_size[i]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cfi_log_buffer.md
# cfi_log_buffer

Parametrised, multi-port log buffer for the CVA6 Control-Flow Integrity path. It sits between the CFI filter and the CFI backend and replaces the separate queue controller plus FIFO pair. Each cycle it accepts up to NR_COMMIT_PORTS filtered logs, compacts them in port order into a DEPTH-entry circular buffer, and presents them one at a time on a valid/ready port. Overflow is handled by a selectable policy: halt the commit stage, or drop and count.

## Interface
- NR_COMMIT_PORTS, default 2: commit ports feeding the buffer, from 1 to 4.
- DEPTH, default 8: buffer entries. Must be a power of two and ≥ NR_COMMIT_PORTS.
- LOG_W, default 128: width of one log entry, in bits.
- OVERFLOW_MODE, default 0: 0 = HALT policy, 1 = DROP policy.
- HALT_MARGIN, default NR_COMMIT_PORTS: minimum number of free entries required to keep halt_o low. Must be ≥ NR_COMMIT_PORTS and ≤ DEPTH.
- CNT_W, default 16: width of the drop counter.
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: reset. Asynchronous and active-low.
- log_i, in, NR_COMMIT_PORTS×LOG_W: candidate logs, one per commit port.
- log_valid_i, in, NR_COMMIT_PORTS: per-port valid.
- flush_i, in, 1: synchronous buffer clear.
- drop_clr_i, in, 1: synchronous clear of drop_cnt_o and overflow_o.
- halt_o, out, 1: commit stall request. Registered.
- log_o, out, LOG_W: head entry.
- log_valid_o, out, 1: the buffer is non-empty.
- log_ready_i, in, 1: the backend accepts the head entry.
- usage_o, out, $clog2(DEPTH+1): current occupancy. Registered.
- drop_cnt_o, out, CNT_W: saturating count of dropped logs.
- overflow_o, out, 1: sticky flag, set when any log is dropped.

## Operation
- State: write pointer, read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH), usage counter, halt register, drop counter, overflow flag.
- Pop: pop = log_valid_o & log_ready_i. log_o is the entry at the read pointer and is valid whenever usage ≠ 0.
- Room this cycle: room = DEPTH − usage + pop. A slot freed by a pop is reusable in the same cycle.
- Push, per cycle:
  - Let k = popcount(log_valid_i).
  - Accept the first min(k, room) valid ports in ascending port index.
  - Write them to consecutive slots starting at the write pointer, with no gaps; invalid ports are skipped.
  - Dropped logs: d = k − accepted. These are always the highest-indexed valid ports.
- usage_next = usage + accepted − pop.
- Write pointer advances by accepted; read pointer advances by pop.
- HALT policy (OVERFLOW_MODE = 0):
  - halt_q ← (DEPTH − usage_next) < HALT_MARGIN.
  - Pushes while halt_o = 1 are a protocol violation. They are still accepted up to the available room; any excess is dropped and counted.
- DROP policy (OVERFLOW_MODE = 1): halt_o is constant 0; excess logs are dropped and counted.
- Drop counter:
  - drop_cnt ← sat(drop_cnt + d), saturating at 2^CNT_W − 1.
  - overflow ← overflow | (d ≠ 0).
  - When drop_clr_i = 1: drop_cnt ← sat(d) and overflow ← (d ≠ 0). Drops in the clear cycle are never lost.
- flush_i (overrides push and pop):
  - Pointers, usage and halt are zeroed. Inputs in the flush cycle are discarded and not counted as drops.
  - drop_cnt_o and overflow_o are not affected.
- Reset values: halt_o 0, log_valid_o 0, usage_o 0, drop_cnt_o 0, overflow_o 0, pointers 0. Buffer storage is not reset.
- Reset mid-operation: all contents are lost immediately (asynchronous reset).

## Timing
- Push-to-output latency is 1 cycle: an entry written in cycle t is visible on log_o and log_valid_o in cycle t+1. There is no fall-through.
- Pop takes effect at the clock edge. log_o, log_valid_o and usage_o update in the next cycle.
- halt_o is registered, so it reflects state after the edge. The commit stage sees it in the same cycle it must stall. With HALT_MARGIN ≥ NR_COMMIT_PORTS, a compliant master never causes drops.
- Full buffer with a simultaneous pop: one push is accepted.
- Empty buffer: log_ready_i is ignored.
- log_o is stable while log_valid_o = 1 and log_ready_i = 0.
- No combinational path from log_valid_i to halt_o or log_valid_o. log_ready_i affects only next-state logic.

## Test plan
- Single push/pop, NR=2, DEPTH=8, HALT:
  - Cycle 0: log_valid_i=01, log_i[0]=0xA, ready=1.
  - Response: cycle 1 log_valid_o=1, log_o=0xA, usage_o=1; cycle 2 usage_o=0, log_valid_o=0.
- Compaction and order:
  - Cycle 0: valid=10, port1=0xB. Cycle 1: valid=11, ports 0xC, 0xD. ready=1 from cycle 3.
  - Response: output order 0xB, 0xC, 0xD; usage_o peaks at 3.
- Halt threshold, DEPTH=4, HALT_MARGIN=2, ready=0:
  - Push 2 logs, then 1 log.
  - Response: after the first push usage_o=2, halt_o=0. After the second, usage_o=3, halt_o=1.
  - Then ready=1 for one cycle: usage_o=2, halt_o=0. No drops.
- Drop mode, DEPTH=4, full, ready=0, valid=11 for 3 cycles:
  - Response: drop_cnt_o=6, overflow_o=1, usage_o=4, halt_o=0.
  - Then drop_clr_i=1 with valid=01: drop_cnt_o=1, overflow_o=1.
- Full buffer with simultaneous pop, DEPTH=4, usage 4, ready=1, valid=11:
  - Response: port 0 accepted, port 1 dropped; usage_o=4, drop_cnt_o=1.
  - Read pointer and write pointer wrap correctly; the FIFO order of the 4 prior entries is preserved.
- Flush and reset:
  - usage 3, flush_i=1 with valid=11.
  - Response: next cycle usage_o=0, log_valid_o=0, halt_o=0, drop_cnt_o unchanged.
  - Asserting rst_ni=0 mid-burst clears all outputs asynchronously.
